present_ctrl: RTL and testbench

//  Round sequencer for the PRESENT-80 iterative encryption core.

---
 rtl/present_pkg.sv | 38 +++
 rtl/comb.sv | 41 ++++
 rtl/present_ctrl.sv | 106 ++++++++++
 tb/tb_present_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared widths, FSM encoding and the PRESENT S-box used by the round sequencer and its datapath.
package present_pkg;

    localparam int ST_W        = 64;
    localparam int KEY_W       = 80;
    localparam int CNT_W       = 5;
    localparam int NROUNDS_MAX = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/comb.sv
// PRESENT-80 round datapath: whitening step when r0=1, otherwise S-box layer, bit permutation
// and key schedule step, finished by adding the freshly scheduled round key.
module comb
    import present_pkg::*;
(
    input  logic [ST_W-1:0]  sp,
    input  logic [KEY_W-1:0] kp,
    input  logic [CNT_W-1:0] cnt,
    input  logic             r0,
    output logic [ST_W-1:0]  sn,
    output logic [KEY_W-1:0] kn
);

    logic [ST_W-1:0]  s_sub;
    logic [ST_W-1:0]  s_perm;
    logic [KEY_W-1:0] k_rot;
    logic [KEY_W-1:0] k_upd;

    // Bit b of nibble j moves to position 16*b + j, i.e. i -> 16*i mod 63 with bit 63 fixed.
    for (genvar j = 0; j < 16; j++) begin : g_nib
        assign s_sub[4*j +: 4] = sbox(sp[4*j +: 4]);
        for (genvar b = 0; b < 4; b++) begin : g_bit
            assign s_perm[16*b + j] = s_sub[4*j + b];
        end
    end

    assign k_rot = {kp[18:0], kp[79:19]};
    assign k_upd = {sbox(k_rot[79:76]), k_rot[75:20], k_rot[19:15] ^ cnt, k_rot[14:0]};

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        if (r0) begin
            sn = sp ^ kp[79:16];
            kn = kp;
        end else begin
            sn = s_perm ^ k_upd[79:16];
            kn = k_upd;
        end
    end

endmodule

// File: rtl/present_ctrl.sv
// Round sequencer for the iterative PRESENT-80 core: owns state/key/round registers, steps the
// `comb` datapath once per clock and moves one job at a time through valid/ready handshakes.
module present_ctrl
    import present_pkg::*;
#(
    parameter int NROUNDS = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ST_W-1:0]  pt,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ST_W-1:0]  ct,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NROUNDS);

    state_t           state, state_nx;
    logic [ST_W-1:0]  sreg, sreg_nx;
    logic [KEY_W-1:0] kreg, kreg_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [ST_W-1:0]  sn;
    logic [KEY_W-1:0] kn;
    logic             r0;

    assign r0 = (cnt == '0);

    comb u_comb (
        .sp  (sreg),
        .kp  (kreg),
        .cnt (cnt),
        .r0  (r0),
        .sn  (sn),
        .kn  (kn)
    );

    always_comb begin
        state_nx  = state;
        sreg_nx   = sreg;
        kreg_nx   = kreg;
        cnt_nx    = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sreg_nx  = pt;
                    kreg_nx  = key;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                sreg_nx = sn;
                kreg_nx = kn;
                // The final round leaves cnt at its last value so the counter can never wrap.
                if (cnt == LAST) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        sreg_nx  = pt;
                        kreg_nx  = key;
                        cnt_nx   = '0;
                        state_nx = RUN;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            kreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            kreg  <= kreg_nx;
            cnt   <= cnt_nx;
        end
    end

    assign ct = sreg;

endmodule

// File: tb/tb_present_ctrl.sv
// Directed bench for present_ctrl: published PRESENT-80 vectors, latency, stall, back-to-back,
// async reset mid-job, RUN-time input noise and a single-round instance.
module tb_present_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] pt, ct;
    logic [79:0] key;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [63:0] pt1, ct1;
    logic [79:0] key1;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
    localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
    localparam logic [63:0] ONES  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [79:0] KONES = 80'hFFFFFFFFFFFFFFFFFFFF;

    always #5 clk = ~clk;

    present_ctrl #(.NROUNDS(31)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pt(pt), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .busy(busy)
    );

    present_ctrl #(.NROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .pt(pt1), .key(key1),
        .out_valid(out_valid1), .out_ready(out_ready1), .ct(ct1), .busy(busy1)
    );

    // Counts edges with the accept edge as clock 1; stops once out_valid is seen or the budget runs out.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept(input logic [63:0] p, input logic [79:0] k, input logic ordy);
        @(negedge clk);
        pt = p; key = k; in_valid = 1'b1; out_ready = ordy;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; pt1 = '0; key1 = '0;
        #12;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || ct !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: rdy/vld/busy=%b ct=%h required 100 ct=0", {in_ready, out_valid, busy}, ct);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic run_vec(input string name, input logic [63:0] p, input logic [79:0] k, input logic [63:0] exp);
        int lat;
        accept(p, k, 1'b1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL %s_run: busy=%b in_ready=%b required 1 0", name, busy, in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 33) begin
            failures++; $display("FAIL %s_latency: got %0d required 33", name, lat);
        end
        checks++;
        if (ct !== exp) begin
            failures++; $display("FAIL %s_ct: got %h required %h", name, ct, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        int lat;
        accept(64'h0, 80'h0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 33) begin
            failures++; $display("FAIL stall_latency: got %0d required 33", lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ct !== CT_00) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d vld=%b rdy=%b ct=%h required 1 0 %h", i, out_valid, in_ready, ct, CT_00);
            end
        end
        // Offer the next job together with the output handshake: it must load on the same edge.
        @(negedge clk);
        pt = ONES; key = 80'h0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_release_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_reload: busy=%b out_valid=%b required 1 0", busy, out_valid);
        end
        wait_out(lat);
        checks++;
        if (lat !== 33 || ct !== CT_F0) begin
            failures++; $display("FAIL stall_next: lat=%0d ct=%h required 33 %h", lat, ct, CT_F0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        // in_valid stays high throughout; the source swaps to job B right after A is accepted.
        accept(ONES, KONES, 1'b1);
        in_valid = 1'b1; pt = 64'h0; key = KONES;
        wait_out(lat);
        checks++;
        if (lat !== 33 || ct !== CT_FF) begin
            failures++; $display("FAIL b2b_first: lat=%0d ct=%h required 33 %h", lat, ct, CT_FF);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_no_bubble: busy=%b out_valid=%b required 1 0", busy, out_valid);
        end
        wait_out(lat);
        checks++;
        if (lat !== 33 || ct !== CT_0F) begin
            failures++; $display("FAIL b2b_second: lat=%0d ct=%h required 33 %h", lat, ct, CT_0F);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midrun_reset();
        int lat;
        accept(64'h0, 80'h0, 1'b1);
        repeat (17) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++; $display("FAIL reset_midrun: rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
        end
        @(negedge clk); rst_n = 1'b1;
        run_vec("after_reset", 64'h0, 80'h0, CT_00);
        // Reset while a finished result waits for the sink.
        accept(ONES, KONES, 1'b0);
        wait_out(lat);
        #2; rst_n = 1'b0; #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++; $display("FAIL reset_done: rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
        end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    endtask

    task automatic test_run_ignore();
        int lat;
        logic bad;
        bad = 1'b0;
        accept(64'h0, 80'h0, 1'b1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) bad = 1'b1;
            in_valid = ~in_valid;
            pt = {$urandom, $urandom};
            key = {$urandom, $urandom, 16'($urandom)};
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            failures++; $display("FAIL ignore_ready: in_ready was 1 during RUN, required 0");
        end
        checks++;
        if (lat !== 33 || ct !== CT_00) begin
            failures++; $display("FAIL ignore_ct: lat=%0d ct=%h required 33 %h", lat, ct, CT_00);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nrounds1();
        int lat;
        logic [63:0] exp;
        // Whitening with K1=0 leaves 0; S gives C in every nibble; P maps bits 2,3 of each nibble
        // to 32..63 -> FFFFFFFF00000000; key step gives K2 = C000000000000000 (counter bit lands below 16).
        exp = 64'h3FFFFFFF00000000;
        @(negedge clk);
        pt1 = 64'h0; key1 = 80'h0; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL nr1_latency: got %0d required 3", lat);
        end
        checks++;
        if (ct1 !== exp) begin
            failures++; $display("FAIL nr1_ct: got %h required %h", ct1, exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        run_vec("pt0_k0", 64'h0, 80'h0, CT_00);
        run_vec("pt0_kF", 64'h0, KONES, CT_0F);
        run_vec("ptF_k0", ONES, 80'h0, CT_F0);
        run_vec("ptF_kF", ONES, KONES, CT_FF);
        test_stall();
        test_back_to_back();
        test_midrun_reset();
        test_run_ignore();
        test_nrounds1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
